// File: rtl/char_display_renderer_if.sv
// Read-side memory bundle of the character display: the VGA read port of
// CharacterDisplayRAM plus the glyph ROM address/data pair.
interface char_display_renderer_if;
  logic       vgaEn;
  logic [7:0] hPixelVGA;
  logic [6:0] vPixelVGA;
  logic [5:0] charCode;
  logic [8:0] glyphAddr;
  logic [7:0] glyphRow;

  modport master (
    output vgaEn, hPixelVGA, vPixelVGA, glyphAddr,
    input  charCode, glyphRow
  );

  modport slave (
    input  vgaEn, hPixelVGA, vPixelVGA, glyphAddr,
    output charCode, glyphRow
  );
endinterface

// File: rtl/char_display_renderer.sv
// Character display pixel pipeline: cell fetch from the display RAM, glyph ROM
// lookup, blinking cursor inversion and RGB332 output with aligned sync/blank.
module char_display_renderer #(
  parameter int unsigned BLINK_FRAMES = 32,
  parameter logic [7:0]  FG_COLOR     = 8'hFF,
  parameter logic [7:0]  BG_COLOR     = 8'h00
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              hCount,
  input  logic [9:0]              vCount,
  input  logic                    hSyncIn,
  input  logic                    vSyncIn,
  input  logic                    blankIn,
  char_display_renderer_if.master mem,
  input  logic                    cursorEn,
  input  logic [7:0]              cursorCol,
  input  logic [6:0]              cursorRow,
  output logic [7:0]              rgb,
  output logic                    hSync,
  output logic                    vSync,
  output logic                    blank
);
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [2:0] xBit;
    logic [2:0] yRow;
    logic       blank;
    logic       hSync;
    logic       vSync;
    logic       cursorHit;
  } sideband_t;

  localparam sideband_t SB_IDLE = '{xBit: 3'd0, yRow: 3'd0, blank: 1'b1,
                                    hSync: 1'b1, vSync: 1'b1, cursorHit: 1'b0};

  typedef enum logic {VISIBLE, HIDDEN} blink_state_e;

  blink_state_e     state, stateNext;
  logic [CNT_W-1:0] frameCnt, frameCntNext;
  logic             vsPrev, vsFall;
  logic             blinkPhase;

  // Blink state register; the falling edge of vSyncIn is registered before use.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= VISIBLE;
      frameCnt <= '0;
      vsPrev   <= 1'b1;
      vsFall   <= 1'b0;
    end else begin
      state    <= stateNext;
      frameCnt <= frameCntNext;
      vsPrev   <= vSyncIn;
      vsFall   <= vsPrev & ~vSyncIn;
    end
  end

  // Frame counter and half-period toggle.
  always_comb begin
    stateNext    = state;
    frameCntNext = frameCnt;
    if (vsFall) begin
      if (frameCnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frameCntNext = '0;
        stateNext    = (state == VISIBLE) ? HIDDEN : VISIBLE;
      end else begin
        frameCntNext = frameCnt + 1'b1;
      end
    end
  end

  assign blinkPhase = (state == VISIBLE);

  logic [7:0] cellCol;
  logic [6:0] cellRow;
  logic       cursorHitNow;
  logic       pixBit;
  sideband_t  sb [DEPTH];

  assign cellCol      = {1'b0, hCount[9:3]};
  assign cellRow      = vCount[9:3];
  assign cursorHitNow = cursorEn & blinkPhase & (cellCol == cursorCol) & (cellRow == cursorRow);
  assign pixBit       = mem.glyphRow[3'd7 - sb[DEPTH-1].xBit];

  // Five-edge pipeline: address, RAM, glyph address, ROM, pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem.vgaEn     <= 1'b0;
      mem.hPixelVGA <= '0;
      mem.vPixelVGA <= '0;
      mem.glyphAddr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) sb[i] <= SB_IDLE;
      rgb   <= 8'h00;
      hSync <= 1'b1;
      vSync <= 1'b1;
      blank <= 1'b1;
    end else begin
      mem.vgaEn     <= ~blankIn;
      mem.hPixelVGA <= cellCol;
      mem.vPixelVGA <= cellRow;
      sb[0] <= '{xBit: hCount[2:0], yRow: vCount[2:0], blank: blankIn,
                 hSync: hSyncIn, vSync: vSyncIn, cursorHit: cursorHitNow};
      for (int unsigned i = 1; i < DEPTH; i++) sb[i] <= sb[i-1];
      mem.glyphAddr <= {mem.charCode, sb[1].yRow};
      // Blank masks stale RAM codes and the cursor alike.
      rgb   <= sb[DEPTH-1].blank ? 8'h00 :
               ((pixBit ^ sb[DEPTH-1].cursorHit) ? FG_COLOR : BG_COLOR);
      hSync <= sb[DEPTH-1].hSync;
      vSync <= sb[DEPTH-1].vSync;
      blank <= sb[DEPTH-1].blank;
    end
  end
endmodule

// File: tb/tb_char_display_renderer.sv
// Bench for char_display_renderer: behavioural RAM/ROM models plus a
// cell/glyph reference model with a fixed output delay queue.
module tb_char_display_renderer;
  localparam int unsigned BLINK = 2;
  localparam logic [7:0]  FG    = 8'hFF;
  localparam logic [7:0]  BG    = 8'h00;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] hCount = '0;
  logic [9:0] vCount = '0;
  logic       hSyncIn = 1'b1, vSyncIn = 1'b1, blankIn = 1'b1;
  logic       cursorEn = 1'b0;
  logic [7:0] cursorCol = '0;
  logic [6:0] cursorRow = '0;
  logic [7:0] rgb;
  logic       hSync, vSync, blank;
  logic [5:0] ramOut = '0;
  logic [7:0] romOut = '0;
  logic [5:0] ram [0:127][0:255];
  logic [7:0] rom [0:511];

  int passCnt = 0;
  int totalCnt = 0;

  char_display_renderer_if mem();
  assign mem.charCode = ramOut;
  assign mem.glyphRow = romOut;

  char_display_renderer #(.BLINK_FRAMES(BLINK), .FG_COLOR(FG), .BG_COLOR(BG)) dut (
    .clk(clk), .reset(reset), .hCount(hCount), .vCount(vCount),
    .hSyncIn(hSyncIn), .vSyncIn(vSyncIn), .blankIn(blankIn), .mem(mem),
    .cursorEn(cursorEn), .cursorCol(cursorCol), .cursorRow(cursorRow),
    .rgb(rgb), .hSync(hSync), .vSync(vSync), .blank(blank)
  );

  always #5 clk = ~clk;

  // Display RAM holds its output while disabled; glyph ROM always reads.
  always @(posedge clk) begin
    if (mem.vgaEn) ramOut <= ram[mem.vPixelVGA][mem.hPixelVGA];
    romOut <= rom[mem.glyphAddr];
  end

  typedef struct {
    logic [10:0] out;
    logic        gaValid;
    logic [8:0]  ga;
  } exp_t;

  exp_t expQ[$];
  bit   phaseVis = 1'b1;
  int   fallCnt = 0;
  bit   lastVs = 1'b1;

  function automatic exp_t model(input logic [9:0] h, input logic [9:0] v,
                                 input logic hs, input logic vs, input logic blk);
    exp_t r;
    int col, row, xb, yr;
    logic [5:0] code;
    logic [7:0] g;
    logic hit, pix;
    col = int'(h[9:3]); row = int'(v[9:3]); xb = int'(h[2:0]); yr = int'(v[2:0]);
    code = ram[row][col];
    g = rom[code * 8 + yr];
    pix = g[7 - xb];
    hit = cursorEn && phaseVis && (col == int'(cursorCol)) && (row == int'(cursorRow));
    r.out = {blk ? 8'h00 : ((pix ^ hit) ? FG : BG), hs, vs, blk};
    r.gaValid = ~blk;
    r.ga = 9'(code * 8 + yr);
    return r;
  endfunction

  task automatic resetModel();
    exp_t idle;
    idle.out = {8'h00, 1'b1, 1'b1, 1'b1};
    idle.gaValid = 1'b0;
    idle.ga = '0;
    expQ.delete();
    repeat (4) expQ.push_back(idle);
    phaseVis = 1'b1;
    fallCnt = 0;
    lastVs = 1'b1;
  endtask

  // Drives one pixel clock and returns the expectations due after that edge.
  task automatic step(input logic [9:0] h, input logic [9:0] v, input logic hs,
                      input logic vs, input logic blk, output exp_t cur, output logic [15:0] addr);
    @(negedge clk);
    reset = 1'b0; hCount = h; vCount = v; hSyncIn = hs; vSyncIn = vs; blankIn = blk;
    expQ.push_back(model(h, v, hs, vs, blk));
    if (lastVs && !vs) begin
      fallCnt++;
      if (fallCnt == int'(BLINK)) begin
        fallCnt = 0;
        phaseVis = ~phaseVis;
      end
    end
    lastVs = vs;
    @(posedge clk); #1;
    cur = expQ.pop_front();
    cur.gaValid = expQ[1].gaValid;
    cur.ga = expQ[1].ga;
    addr = {~blk, 1'b0, h[9:3], v[9:3]};
  endtask

  task automatic doReset();
    repeat (2) begin
      @(negedge clk); reset = 1'b1; blankIn = 1'b1;
      @(posedge clk); #1;
    end
    resetModel();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      reset = 1'b1;
      hCount = 10'($urandom_range(0, 799)); vCount = 10'($urandom_range(0, 524));
      hSyncIn = 1'($urandom_range(0, 1)); vSyncIn = 1'($urandom_range(0, 1));
      blankIn = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      totalCnt++;
      if ({rgb, hSync, vSync, blank, mem.vgaEn, mem.glyphAddr} !== {8'h00, 4'b1110, 9'h000})
        $display("FAIL reset_values: got %h want %h", {rgb, hSync, vSync, blank, mem.vgaEn, mem.glyphAddr},
                 {8'h00, 4'b1110, 9'h000});
      else passCnt++;
    end
    resetModel();
  endtask

  task automatic test_glyph_render();
    exp_t e; logic [15:0] a; logic blk; logic [7:0] want;
    cursorEn = 1'b0;
    ram[1][2] = 6'h05;
    rom[9'h028] = 8'hA0;
    for (int i = 0; i < 12; i++) begin
      blk = (i >= 8);
      step(10'(16 + i), 10'd8, 1'b1, 1'b1, blk, e, a);
      totalCnt++; if ({mem.vgaEn, mem.hPixelVGA, mem.vPixelVGA} !== a) $display("FAIL glyph_ram_addr: got %h want %h", {mem.vgaEn, mem.hPixelVGA, mem.vPixelVGA}, a); else passCnt++;
      if (e.gaValid) begin totalCnt++; if (mem.glyphAddr !== e.ga) $display("FAIL glyph_rom_addr: got %h want %h", mem.glyphAddr, e.ga); else passCnt++; end
      totalCnt++; if ({rgb, hSync, vSync, blank} !== e.out) $display("FAIL glyph_out: got %h want %h", {rgb, hSync, vSync, blank}, e.out); else passCnt++;
      if (i >= 2 && i < 10) begin
        totalCnt++; if (mem.glyphAddr !== 9'h028) $display("FAIL glyph_addr_const: got %h want 028", mem.glyphAddr); else passCnt++;
      end
      if (i >= 4) begin
        want = (i == 4 || i == 6) ? 8'hFF : 8'h00;
        totalCnt++; if (rgb !== want) $display("FAIL glyph_pattern: got %h want %h", rgb, want); else passCnt++;
      end
    end
  endtask

  task automatic test_blank();
    exp_t e; logic [15:0] a; logic blk;
    ram[3][4] = 6'h2A;
    for (int r = 0; r < 8; r++) rom[6'h2A * 8 + r] = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      blk = (i >= 4 && i < 12);
      step(10'(32 + i % 8), 10'd24, 1'b1, 1'b1, blk, e, a);
      totalCnt++; if ({mem.vgaEn, mem.hPixelVGA, mem.vPixelVGA} !== a) $display("FAIL blank_ram_addr: got %h want %h", {mem.vgaEn, mem.hPixelVGA, mem.vPixelVGA}, a); else passCnt++;
      if (e.gaValid) begin totalCnt++; if (mem.glyphAddr !== e.ga) $display("FAIL blank_rom_addr: got %h want %h", mem.glyphAddr, e.ga); else passCnt++; end
      totalCnt++; if ({rgb, hSync, vSync, blank} !== e.out) $display("FAIL blank_out: got %h want %h", {rgb, hSync, vSync, blank}, e.out); else passCnt++;
      if (i >= 8 && i < 16) begin
        totalCnt++; if ({rgb, blank} !== {8'h00, 1'b1}) $display("FAIL blank_masked: got %h want 001", {rgb, blank}); else passCnt++;
      end
    end
  endtask

  task automatic test_sync_align();
    exp_t e; logic [15:0] a;
    cursorEn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(10'(100 + i), 10'd200, (i != 2), (i != 9), 1'b0, e, a);
      totalCnt++; if ({rgb, hSync, vSync, blank} !== e.out) $display("FAIL sync_out: got %h want %h", {rgb, hSync, vSync, blank}, e.out); else passCnt++;
      totalCnt++; if ({hSync, vSync} !== {(i != 6), (i != 13)}) $display("FAIL sync_delay: got %b want %b", {hSync, vSync}, {(i != 6), (i != 13)}); else passCnt++;
    end
  endtask

  task automatic test_cursor_blink();
    exp_t e; logic [15:0] a; logic blk, vs; logic [7:0] want;
    doReset();
    ram[1][2] = 6'h11;
    for (int r = 0; r < 8; r++) rom[6'h11 * 8 + r] = 8'hF0;
    cursorEn = 1'b1; cursorCol = 8'd2; cursorRow = 7'd1;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 24; i++) begin
        blk = (i >= 8);
        vs = !(p < 2 && (i == 12 || i == 13 || i == 18 || i == 19));
        step(blk ? 10'd0 : 10'(16 + i), blk ? 10'd0 : 10'd8, 1'b1, vs, blk, e, a);
        totalCnt++; if ({rgb, hSync, vSync, blank} !== e.out) $display("FAIL cursor_out: got %h want %h", {rgb, hSync, vSync, blank}, e.out); else passCnt++;
        if (i >= 4 && i < 12) begin
          want = ((i < 8) ^ (p != 1)) ? FG : BG;
          totalCnt++; if (rgb !== want) $display("FAIL cursor_blink_phase%0d: got %h want %h", p, rgb, want); else passCnt++;
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    exp_t e; logic [15:0] a; logic blk, vs; logic [7:0] want;
    // Three falls: HIDDEN after two, the third leaves frameCnt mid-count.
    for (int i = 0; i < 18; i++) begin
      step(10'd0, 10'd0, 1'b1, !(i % 6 < 2), 1'b1, e, a);
      totalCnt++; if ({rgb, hSync, vSync, blank} !== e.out) $display("FAIL midframe_pre_out: got %h want %h", {rgb, hSync, vSync, blank}, e.out); else passCnt++;
    end
    for (int i = 0; i < 6; i++) begin
      step(10'(16 + i), 10'd8, 1'b1, 1'b1, 1'b0, e, a);
      totalCnt++; if ({rgb, hSync, vSync, blank} !== e.out) $display("FAIL midframe_render_out: got %h want %h", {rgb, hSync, vSync, blank}, e.out); else passCnt++;
    end
    repeat (2) begin
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      totalCnt++;
      if ({rgb, hSync, vSync, blank, mem.vgaEn} !== {8'h00, 4'b1110})
        $display("FAIL midframe_reset: got %h want %h", {rgb, hSync, vSync, blank, mem.vgaEn}, {8'h00, 4'b1110});
      else passCnt++;
    end
    resetModel();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 24; i++) begin
        blk = (i >= 8);
        vs = !(p == 0 && (i == 12 || i == 13));
        step(blk ? 10'd0 : 10'(16 + i), blk ? 10'd0 : 10'd8, 1'b1, vs, blk, e, a);
        totalCnt++; if ({rgb, hSync, vSync, blank} !== e.out) $display("FAIL midframe_post_out: got %h want %h", {rgb, hSync, vSync, blank}, e.out); else passCnt++;
        if (i >= 4 && i < 12) begin
          want = (i < 8) ? BG : FG;
          totalCnt++; if (rgb !== want) $display("FAIL midframe_blink_restart%0d: got %h want %h", p, rgb, want); else passCnt++;
        end
      end
    end
  endtask

  task automatic test_random_stream();
    exp_t e; logic [15:0] a; int len, h0, v0; logic blk, hs;
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 4) == 0) begin
        for (int i = 0; i < 5; i++) begin
          step(10'($urandom_range(0, 799)), 10'($urandom_range(0, 524)), 1'b1, (i >= 2), 1'b1, e, a);
          totalCnt++; if ({rgb, hSync, vSync, blank} !== e.out) $display("FAIL random_vs_out: got %h want %h", {rgb, hSync, vSync, blank}, e.out); else passCnt++;
        end
      end
      len = $urandom_range(8, 24);
      h0 = $urandom_range(0, 799 - len);
      v0 = $urandom_range(0, 524);
      cursorEn = 1'($urandom_range(0, 3) != 0);
      cursorRow = ($urandom_range(0, 1) == 1) ? 7'(v0 / 8) : 7'($urandom_range(0, 65));
      cursorCol = 8'((h0 + $urandom_range(0, len - 1)) / 8);
      for (int i = 0; i < len; i++) begin
        blk = ($urandom_range(0, 4) == 0);
        hs = ($urandom_range(0, 7) != 0);
        step(10'(h0 + i), 10'(v0), hs, 1'b1, blk, e, a);
        totalCnt++; if ({mem.vgaEn, mem.hPixelVGA, mem.vPixelVGA} !== a) $display("FAIL random_ram_addr: got %h want %h", {mem.vgaEn, mem.hPixelVGA, mem.vPixelVGA}, a); else passCnt++;
        if (e.gaValid) begin totalCnt++; if (mem.glyphAddr !== e.ga) $display("FAIL random_rom_addr: got %h want %h", mem.glyphAddr, e.ga); else passCnt++; end
        totalCnt++; if ({rgb, hSync, vSync, blank} !== e.out) $display("FAIL random_out: got %h want %h", {rgb, hSync, vSync, blank}, e.out); else passCnt++;
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 256; c++) ram[r][c] = 6'($urandom);
    for (int i = 0; i < 512; i++) rom[i] = 8'($urandom);
    test_reset();
    test_glyph_render();
    test_blank();
    test_sync_align();
    test_cursor_blink();
    test_reset_midframe();
    test_random_stream();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
